// File: rtl/regfile_sweep.sv
// Register file with two combinational read ports, one write port, x0 hardwired to zero,
// an a0 mirror output and a zeroing sweep after reset or clr. Optional macro: REGFILE_BYPASS_EN.
module regfile_sweep #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned A0_INDEX   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] AD1,
  input  logic [ADDR_WIDTH-1:0] AD2,
  input  logic [ADDR_WIDTH-1:0] AD3,
  input  logic                  WE3,
  input  logic [DATA_WIDTH-1:0] WD3,
  output logic [DATA_WIDTH-1:0] RD1,
  output logic [DATA_WIDTH-1:0] RD2,
  output logic [DATA_WIDTH-1:0] a0,
  output logic                  ready
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A0_ADDR   = ADDR_WIDTH'(A0_INDEX);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = '0;

  typedef enum logic {ST_SWEEP = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [ADDR_WIDTH-1:0]   w_ptr_nxt;
  logic                    r_ready;
  logic                    w_ready_nxt;

  logic                    w_wr_en;
  logic [ADDR_WIDTH-1:0]   w_wr_addr;
  logic [DATA_WIDTH-1:0]   w_wr_data;
  logic                    w_user_wr;

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  // State register: sweep pointer and ready flag live alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_SWEEP;
      r_ptr   <= FIRST_IDX;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next-state logic; the pointer stops at the last register instead of wrapping
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_ready_nxt = r_ready;
    if (clr) begin
      w_state_nxt = ST_SWEEP;
      w_ptr_nxt   = FIRST_IDX;
      w_ready_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_SWEEP: begin
          if (r_ptr == LAST_IDX) begin
            w_state_nxt = ST_RUN;
            w_ready_nxt = 1'b1;
          end else begin
            w_ptr_nxt = r_ptr + FIRST_IDX;
          end
        end
        ST_RUN: begin
          w_ready_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_SWEEP;
          w_ptr_nxt   = FIRST_IDX;
          w_ready_nxt = 1'b0;
        end
      endcase
    end
  end

  // Output logic: array write port selection (sweep zeroing or user write)
  always_comb begin
    w_user_wr = (r_state == ST_RUN) && !clr && WE3 && (AD3 != ZERO_ADDR);
    w_wr_en   = 1'b0;
    w_wr_addr = r_ptr;
    w_wr_data = '0;
    if (r_state == ST_SWEEP && !clr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = r_ptr;
      w_wr_data = '0;
    end else if (w_user_wr) begin
      w_wr_en   = 1'b1;
      w_wr_addr = AD3;
      w_wr_data = WD3;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Read ports: forced to zero during sweep, x0 always reads zero
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    a0  = '0;
    if (r_state == ST_RUN) begin
      RD1 = (AD1 == ZERO_ADDR) ? '0 : r_mem[AD1];
      RD2 = (AD2 == ZERO_ADDR) ? '0 : r_mem[AD2];
      a0  = r_mem[A0_INDEX];
`ifdef REGFILE_BYPASS_EN
      if (w_user_wr && (AD3 == AD1)) RD1 = WD3;
      if (w_user_wr && (AD3 == AD2)) RD2 = WD3;
      if (w_user_wr && (AD3 == A0_ADDR)) a0 = WD3;
`endif
    end
  end

  assign ready = r_ready;

`ifndef REGFILE_BYPASS_EN
  logic w_unused;
  assign w_unused = ^A0_ADDR;
`endif

endmodule

// File: tb/tb_regfile_sweep.sv
// Self-checking bench for regfile_sweep: reset sweep, vector table in RUN, and
// hand-written clear/reset/same-cycle sequences.
module tb_regfile_sweep;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic          clr;
  logic [AW-1:0] AD1, AD2, AD3;
  logic          WE3;
  logic [DW-1:0] WD3;
  logic [DW-1:0] RD1, RD2, a0;
  logic          ready;

  int checks   = 0;
  int failures = 0;

  regfile_sweep #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .A0_INDEX(10)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .AD1(AD1), .AD2(AD2), .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .RD1(RD1), .RD2(RD2), .a0(a0), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;
    logic [AW-1:0] ad1;
    logic [AW-1:0] ad2;
    logic [DW-1:0] exp_rd1;
    logic [DW-1:0] exp_rd2;
    logic [DW-1:0] exp_a0;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect ready low for n-1 edges and high after the n-th
  task automatic expect_sweep(input int n, input string name);
    for (int k = 1; k <= n; k++) begin
      tick();
      check($sformatf("%s_ready_edge%0d", name, k), DW'(ready), DW'(k == n));
    end
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    WE3 = 1'b1; AD3 = a; WD3 = d;
    tick();
    WE3 = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; WE3 = 1'b0;
    AD1 = 5'd5; AD2 = 5'd5; AD3 = 5'd0; WD3 = '0;

    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd6,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    vecs[3] = '{1'b1, 5'd10, 32'h0000002A, 5'd10, 5'd5,  32'h0000002A, 32'hDEADBEEF, 32'h0000002A};
    vecs[4] = '{1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd1,  32'hA5A5A5A5, 32'h0,        32'h0000002A};
    vecs[5] = '{1'b1, 5'd1,  32'h00000001, 5'd1,  5'd31, 32'h00000001, 32'hA5A5A5A5, 32'h0000002A};
    vecs[6] = '{1'b0, 5'd5,  32'hFFFFFFFF, 5'd5,  5'd10, 32'hDEADBEEF, 32'h0000002A, 32'h0000002A};
    vecs[7] = '{1'b1, 5'd7,  32'h00000055, 5'd7,  5'd8,  32'h00000055, 32'h0,        32'h0000002A};

    // Reset held 3 cycles, then 31-edge sweep with writes to reg3 issued throughout
    repeat (3) tick();
    check("rst_ready", DW'(ready), '0);
    check("rst_rd1", RD1, '0);
    check("rst_a0", a0, '0);
    rst_n = 1'b1;
    WE3 = 1'b1; AD3 = 5'd3; WD3 = 32'hFFFFFFFF;
    for (int k = 1; k <= 31; k++) begin
      tick();
      check($sformatf("sweep0_ready_edge%0d", k), DW'(ready), DW'(k == 31));
      if (k < 31) check($sformatf("sweep0_rd1_edge%0d", k), RD1, '0);
    end
    WE3 = 1'b0; AD1 = 5'd3;
    #1;
    check("sweep_write_ignored", RD1, '0);

    // Vector table in RUN: write on one edge, then read with the write deasserted
    foreach (vecs[i]) begin
      WE3 = vecs[i].we; AD3 = vecs[i].ad3; WD3 = vecs[i].wd3;
      AD1 = vecs[i].ad1; AD2 = vecs[i].ad2;
      tick();
      WE3 = 1'b0;
      #1;
      check($sformatf("vec%0d_rd1", i), RD1, vecs[i].exp_rd1);
      check($sformatf("vec%0d_rd2", i), RD2, vecs[i].exp_rd2);
      check($sformatf("vec%0d_a0", i), a0, vecs[i].exp_a0);
    end

    // Same-cycle read of the address being written
    write_reg(5'd4, 32'h00000011);
    WE3 = 1'b1; AD3 = 5'd4; WD3 = 32'h00000022; AD1 = 5'd4;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_rd1", RD1, 32'h00000022);
`else
    check("same_cycle_rd1", RD1, 32'h00000011);
`endif
    tick();
    WE3 = 1'b0;
    #1;
    check("after_edge_rd1", RD1, 32'h00000022);

    // clr with a simultaneous write: write dropped, sweep restarts
    clr = 1'b1; WE3 = 1'b1; AD3 = 5'd8; WD3 = 32'h00000099; AD1 = 5'd7; AD2 = 5'd8;
    #1;
    check("clr_pre_edge_rd1", RD1, 32'h00000055);
    check("clr_pre_edge_rd2", RD2, 32'h0);
    tick();
    clr = 1'b0; WE3 = 1'b0;
    #1;
    check("clr_ready_drop", DW'(ready), '0);
    check("clr_rd1_forced", RD1, '0);
    expect_sweep(31, "clr");
    check("clr_rd1_reg7", RD1, '0);
    check("clr_rd2_reg8", RD2, '0);
    check("clr_a0", a0, '0);
    AD1 = 5'd31; AD2 = 5'd1;
    #1;
    check("clr_rd1_reg31", RD1, '0);
    check("clr_rd2_reg1", RD2, '0);

    // clr held high keeps the block in sweep
    clr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (k % 10 == 9) check($sformatf("clr_hold_ready_%0d", k), DW'(ready), '0);
    end
    clr = 1'b0;
    expect_sweep(31, "hold");

    // Asynchronous reset mid-RUN takes effect between edges
    write_reg(5'd12, 32'h12345678);
    AD1 = 5'd12;
    #1;
    check("pre_rst_rd1", RD1, 32'h12345678);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready", DW'(ready), '0);
    check("midrun_rst_rd1", RD1, '0);
    tick();
    rst_n = 1'b1;
    // Reset mid-sweep
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midsweep_rst_ready", DW'(ready), '0);
    tick();
    rst_n = 1'b1;
    expect_sweep(31, "rst2");
    check("rst2_rd1_reg12", RD1, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
